sc_dmem_arbiter: RTL and testbench
==================================

SC_DMEM_ARBITER -- requirements
Module: sc_dmem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 3, meaning the number of consecutive cycles port 1 may be denied before it is forced ahead of port 0 (legal range 1..15).
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have ports p0_req, input, 1, and p1_req, input, 1, meaning the port requests a data-memory access this cycle.
REQ-005 The block SHALL have ports p0_we, input, 1, and p1_we, input, 1, meaning the request is a write (1) or a read (0).
REQ-006 The block SHALL have ports p0_addr, input, 32, and p1_addr, input, 32, meaning the byte address; only bits [6:2] reach memory.
REQ-007 The block SHALL have ports p0_wdata, input, 32, and p1_wdata, input, 32, meaning the write data.
REQ-008 The block SHALL have ports p0_gnt, output, 1, and p1_gnt, output, 1, meaning the request is accepted this cycle.
REQ-009 The block SHALL have ports p0_rvalid, output, 1, and p1_rvalid, output, 1, meaning read data for that port is valid this cycle.
REQ-010 The block SHALL have ports p0_rdata, output, 32, and p1_rdata, output, 32, meaning the read data, qualified by the matching rvalid.
REQ-011 The block SHALL have port mem_addr, output, 5, meaning the word address to the data RAM.
REQ-012 The block SHALL have port mem_wdata, output, 32, meaning the write data to the data RAM.
REQ-013 The block SHALL have port mem_we, output, 1, meaning the write enable to the data RAM.
REQ-014 The block SHALL have port mem_rdata, input, 32, meaning the RAM read data, valid one cycle after the address is presented.

Function
REQ-015 The block SHALL grant at most one port per cycle; p0_gnt and p1_gnt SHALL never both be 1.
REQ-016 Grants SHALL be combinational from the current requests and registered state; a port is granted in the same cycle it requests if selected.
REQ-017 Selection: p1 only requesting -> p1; p0 only -> p0; both requesting -> p0, unless starve_cnt == STARVE_LIMIT, in which case p1.
REQ-018 starve_cnt (4-bit register) SHALL increment, saturating at STARVE_LIMIT, on each edge where p1_req=1 and p1_gnt=0, and SHALL clear on an edge where p1_gnt=1 or p1_req=0.
REQ-019 mem_addr and mem_wdata SHALL carry addr[6:2] and wdata of the granted port; when neither port is granted they SHALL carry p0's values.
REQ-020 mem_we SHALL equal (p0_gnt & p0_we) | (p1_gnt & p1_we); a cycle with no grant SHALL have mem_we=0.
REQ-021 A granted read SHALL set a registered pending flag for that port; the following cycle that port's rvalid SHALL be 1 with rdata = mem_rdata; rvalid SHALL be 0 otherwise.
REQ-022 A granted write SHALL produce no rvalid.
REQ-023 Back-to-back reads, same or alternating ports, SHALL be sustained at one per cycle, each returning exactly one rvalid one cycle later.
REQ-024 p0_rdata and p1_rdata SHALL both be driven from mem_rdata; only rvalid distinguishes ownership.
REQ-025 A denied port SHALL hold req, we, addr and wdata stable until granted; the block does not buffer requests.

Reset
REQ-026 While reset=1: p0_gnt=p1_gnt=0, mem_we=0, p0_rvalid=p1_rvalid=0, starve_cnt=0, pending flags=0, asynchronously and regardless of requests.
REQ-027 Reset asserted mid-operation SHALL discard any pending read; no rvalid SHALL appear in the cycle after reset deasserts.
REQ-028 The first cycle after reset SHALL arbitrate normally with starve_cnt=0.

Verification
REQ-029 p0 reads addr 0x0000_0010 alone -> p0_gnt=1, mem_addr=5'd4, mem_we=0; next cycle p0_rvalid=1 with p0_rdata = RAM word 4.
REQ-030 p1 writes 0xDEAD_BEEF to 0x0000_0008 alone -> p1_gnt=1, mem_we=1, mem_addr=5'd2; no p1_rvalid; a later p0 read of 0x8 returns 0xDEAD_BEEF.
REQ-031 With STARVE_LIMIT=3, both ports request continuously -> grants p0,p0,p0,p1,p0,p0,p0,p1...; starve_cnt saturates at 3 and clears after each p1 grant.
REQ-032 Alternating reads p0@0x4, p1@0x8, p0@0xC on consecutive cycles -> rvalid p0,p1,p0 on the following three consecutive cycles with the matching words.
REQ-033 reset pulsed in the cycle a p1 read is granted -> gnt and mem_we drop immediately; no p1_rvalid after release; starve_cnt=0.
REQ-034 Neither port requests for 10 cycles -> both gnt, both rvalid and mem_we stay 0 throughout.

Source files
------------

// File: rtl/sc_dmem_arbiter.sv
// Two-port data-memory arbiter: fixed p0 priority with a starvation override
// for p1, single-cycle RAM access and one-cycle-later read return.
module sc_dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  localparam int unsigned ADDR_W = 32,
  localparam int unsigned DATA_W = 32,
  localparam int unsigned MEM_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             pend0_q, pend0_d;
  logic             pend1_q, pend1_d;
  logic             gnt0_c, gnt1_c;
  logic             unused_addr_bits;

  // Grant selection; reset forces both grants low asynchronously.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!reset) begin
      if (p0_req && p1_req) begin
        if (starve_cnt_q == LIMIT) begin
          gnt1_c = 1'b1;
        end else begin
          gnt0_c = 1'b1;
        end
      end else if (p0_req) begin
        gnt0_c = 1'b1;
      end else if (p1_req) begin
        gnt1_c = 1'b1;
      end
    end
  end

  assign p0_gnt = gnt0_c;
  assign p1_gnt = gnt1_c;

  // RAM side follows the granted port; p0's values are parked when idle.
  assign mem_addr  = gnt1_c ? p1_addr[6:2] : p0_addr[6:2];
  assign mem_wdata = gnt1_c ? p1_wdata : p0_wdata;
  assign mem_we    = (gnt0_c & p0_we) | (gnt1_c & p1_we);

  // Read data is shared; ownership is carried only by the pending flags.
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;
  assign p0_rvalid = pend0_q;
  assign p1_rvalid = pend1_q;

  // Byte-lane and upper address bits never reach the 32-word RAM.
  assign unused_addr_bits = ^{p0_addr[ADDR_W-1:7], p0_addr[1:0],
                              p1_addr[ADDR_W-1:7], p1_addr[1:0]};

  // Next-state: starvation counter and read-pending flags.
  always_comb begin
    starve_cnt_d = '0;
    pend0_d      = gnt0_c & ~p0_we;
    pend1_d      = gnt1_c & ~p1_we;
    if (p1_req && !gnt1_c) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q
                                             : starve_cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
      pend0_q      <= 1'b0;
      pend1_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      pend0_q      <= pend0_d;
      pend1_q      <= pend1_d;
    end
  end

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Directed bench for sc_dmem_arbiter with a small synchronous RAM model.
module tb_sc_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 1'b0, p1_req = 1'b0;
  logic        p0_we = 1'b0, p1_we = 1'b0;
  logic [31:0] p0_addr = '0, p1_addr = '0;
  logic [31:0] p0_wdata = '0, p1_wdata = '0;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata = '0;

  logic [31:0] ram [32];
  int passed = 0;
  int total  = 0;

  sc_dmem_arbiter #(.STARVE_LIMIT(3)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // RAM: write on we, registered read of the presented address.
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic set_p0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
  endtask

  task automatic set_p1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
  endtask

  task automatic idle();
    set_p0(1'b0, 1'b0, 32'h0, 32'h0);
    set_p1(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Reset holds grants, mem_we and rvalid low even with requests present.
  task automatic test_reset();
    @(negedge clock);
    set_p0(1'b1, 1'b1, 32'h4, 32'h1);
    set_p1(1'b1, 1'b1, 32'h8, 32'h2);
    #1;
    total++; if (p0_gnt !== 1'b0) $display("FAIL rst_p0_gnt got=%b exp=0", p0_gnt); else passed++;
    total++; if (p1_gnt !== 1'b0) $display("FAIL rst_p1_gnt got=%b exp=0", p1_gnt); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got=%b exp=0", mem_we); else passed++;
    total++; if ({p0_rvalid, p1_rvalid} !== 2'b00)
      $display("FAIL rst_rvalid got=%b exp=00", {p0_rvalid, p1_rvalid}); else passed++;
    @(negedge clock);
    idle();
    reset = 1'b0;
  endtask

  // Single p0 read of 0x10 returns RAM word 4 a cycle later.
  task automatic test_read_p0();
    @(negedge clock);
    set_p0(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    #1;
    total++; if ({p0_gnt, p1_gnt} !== 2'b10)
      $display("FAIL rd_gnt got=%b exp=10", {p0_gnt, p1_gnt}); else passed++;
    total++; if (mem_addr !== 5'd4) $display("FAIL rd_mem_addr got=%0d exp=4", mem_addr); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL rd_mem_we got=%b exp=0", mem_we); else passed++;
    @(negedge clock);
    idle();
    #1;
    total++; if ({p0_rvalid, p1_rvalid} !== 2'b10)
      $display("FAIL rd_rvalid got=%b exp=10", {p0_rvalid, p1_rvalid}); else passed++;
    total++; if (p0_rdata !== 32'hA500_0004)
      $display("FAIL rd_rdata got=%h exp=a5000004", p0_rdata); else passed++;
    @(negedge clock);
    #1;
    total++; if ({p0_rvalid, p1_rvalid} !== 2'b00)
      $display("FAIL rd_rvalid_drop got=%b exp=00", {p0_rvalid, p1_rvalid}); else passed++;
  endtask

  // Alternating and same-port reads at one per cycle.
  task automatic test_back_to_back();
    @(negedge clock);
    set_p0(1'b1, 1'b0, 32'h4, 32'h0);
    @(negedge clock);
    set_p0(1'b0, 1'b0, 32'h0, 32'h0);
    set_p1(1'b1, 1'b0, 32'h8, 32'h0);
    #1;
    total++; if ({p0_rvalid, p1_rvalid, p0_rdata} !== {2'b10, 32'hA500_0001})
      $display("FAIL b2b_1 got=%b%b %h exp=10 a5000001", p0_rvalid, p1_rvalid, p0_rdata); else passed++;
    total++; if (p1_gnt !== 1'b1) $display("FAIL b2b_p1_gnt got=%b exp=1", p1_gnt); else passed++;
    @(negedge clock);
    set_p1(1'b0, 1'b0, 32'h0, 32'h0);
    set_p0(1'b1, 1'b0, 32'hC, 32'h0);
    #1;
    total++; if ({p0_rvalid, p1_rvalid, p1_rdata} !== {2'b01, 32'hA500_0002})
      $display("FAIL b2b_2 got=%b%b %h exp=01 a5000002", p0_rvalid, p1_rvalid, p1_rdata); else passed++;
    @(negedge clock);
    set_p0(1'b1, 1'b0, 32'h14, 32'h0);
    #1;
    total++; if ({p0_rvalid, p1_rvalid, p0_rdata} !== {2'b10, 32'hA500_0003})
      $display("FAIL b2b_3 got=%b%b %h exp=10 a5000003", p0_rvalid, p1_rvalid, p0_rdata); else passed++;
    @(negedge clock);
    set_p0(1'b1, 1'b0, 32'h18, 32'h0);
    #1;
    total++; if ({p0_rvalid, p0_rdata} !== {1'b1, 32'hA500_0005})
      $display("FAIL b2b_4 got=%b %h exp=1 a5000005", p0_rvalid, p0_rdata); else passed++;
    @(negedge clock);
    idle();
    #1;
    total++; if ({p0_rvalid, p0_rdata} !== {1'b1, 32'hA500_0006})
      $display("FAIL b2b_5 got=%b %h exp=1 a5000006", p0_rvalid, p0_rdata); else passed++;
    @(negedge clock);
    #1;
    total++; if ({p0_rvalid, p1_rvalid} !== 2'b00)
      $display("FAIL b2b_end got=%b exp=00", {p0_rvalid, p1_rvalid}); else passed++;
  endtask

  // p1 write lands in RAM, raises no rvalid, and reads back via p0.
  task automatic test_write_p1();
    @(negedge clock);
    set_p1(1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    #1;
    total++; if ({p0_gnt, p1_gnt} !== 2'b01)
      $display("FAIL wr_gnt got=%b exp=01", {p0_gnt, p1_gnt}); else passed++;
    total++; if ({mem_we, mem_addr} !== {1'b1, 5'd2})
      $display("FAIL wr_mem got=%b %0d exp=1 2", mem_we, mem_addr); else passed++;
    total++; if (mem_wdata !== 32'hDEAD_BEEF)
      $display("FAIL wr_wdata got=%h exp=deadbeef", mem_wdata); else passed++;
    @(negedge clock);
    idle();
    #1;
    total++; if ({p0_rvalid, p1_rvalid} !== 2'b00)
      $display("FAIL wr_no_rvalid got=%b exp=00", {p0_rvalid, p1_rvalid}); else passed++;
    @(negedge clock);
    set_p0(1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clock);
    idle();
    #1;
    total++; if ({p0_rvalid, p0_rdata} !== {1'b1, 32'hDEAD_BEEF})
      $display("FAIL wr_readback got=%b %h exp=1 deadbeef", p0_rvalid, p0_rdata); else passed++;
  endtask

  // Continuous contention: p1 wins every fourth cycle; rvalid tracks owner.
  task automatic contend(input string tag);
    logic [7:0] p1_pat;
    logic       prev_p1;
    p1_pat = 8'b1000_1000;
    prev_p1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      set_p0(1'b1, 1'b0, 32'h4, 32'h0);
      set_p1(1'b1, 1'b0, 32'h8, 32'h0);
      #1;
      total++; if ({p0_gnt, p1_gnt} !== {~p1_pat[i], p1_pat[i]})
        $display("FAIL %s_gnt[%0d] got=%b exp=%b", tag, i, {p0_gnt, p1_gnt}, {~p1_pat[i], p1_pat[i]});
      else passed++;
      if (i > 0) begin
        total++; if ({p0_rvalid, p1_rvalid} !== {~prev_p1, prev_p1})
          $display("FAIL %s_rvalid[%0d] got=%b exp=%b", tag, i, {p0_rvalid, p1_rvalid}, {~prev_p1, prev_p1});
        else passed++;
      end
      prev_p1 = p1_pat[i];
    end
    @(negedge clock);
    idle();
  endtask

  task automatic test_starvation();
    contend("starve");
  endtask

  // Reset during a granted p1 read: grant drops, read discarded, counter cleared.
  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      set_p0(1'b1, 1'b0, 32'h4, 32'h0);
      set_p1(1'b1, 1'b0, 32'h8, 32'h0);
    end
    @(negedge clock);
    set_p0(1'b0, 1'b0, 32'h0, 32'h0);
    set_p1(1'b1, 1'b0, 32'h1C, 32'h0);
    #1;
    total++; if (p1_gnt !== 1'b1) $display("FAIL rmid_pre_gnt got=%b exp=1", p1_gnt); else passed++;
    reset = 1'b1;
    #1;
    total++; if ({p0_gnt, p1_gnt, mem_we} !== 3'b000)
      $display("FAIL rmid_drop got=%b exp=000", {p0_gnt, p1_gnt, mem_we}); else passed++;
    @(negedge clock);
    total++; if (dut.starve_cnt_q !== 4'd0)
      $display("FAIL rmid_starve got=%0d exp=0", dut.starve_cnt_q); else passed++;
    idle();
    reset = 1'b0;
    #1;
    total++; if ({p0_rvalid, p1_rvalid} !== 2'b00)
      $display("FAIL rmid_rvalid0 got=%b exp=00", {p0_rvalid, p1_rvalid}); else passed++;
    @(negedge clock);
    #1;
    total++; if ({p0_rvalid, p1_rvalid} !== 2'b00)
      $display("FAIL rmid_rvalid1 got=%b exp=00", {p0_rvalid, p1_rvalid}); else passed++;
    contend("postrst");
  endtask

  // Ten idle cycles: nothing granted, nothing written, p0 address parked.
  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      set_p0(1'b0, 1'b1, 32'h7C, 32'h1234_5678);
      set_p1(1'b0, 1'b1, 32'h40, 32'h0);
      #1;
      total++; if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we} !== 5'b0)
        $display("FAIL idle[%0d] got=%b exp=00000", i, {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we});
      else passed++;
    end
    total++; if ({mem_addr, mem_wdata} !== {5'd31, 32'h1234_5678})
      $display("FAIL idle_park got=%0d %h exp=31 12345678", mem_addr, mem_wdata); else passed++;
    @(negedge clock);
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 32'hA500_0000 | 32'(i);
    test_reset();
    test_read_p0();
    test_back_to_back();
    test_write_p1();
    test_starvation();
    test_reset_mid();
    test_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
